// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle MIPS controller.
package mips_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH,
      S_DECODE,
      S_MEMADR,
      S_MEMRD,
      S_MEMWB,
      S_MEMWR,
      S_REXEC,
      S_RWB,
      S_IEXEC,
      S_IWB,
      S_BRANCH,
      S_JUMP
   } state_e;

   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'b00,
      ALUOP_SUB   = 2'b01,
      ALUOP_FUNCT = 2'b10,
      ALUOP_OR    = 2'b11
   } aluop_e;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ORI   = 6'b001101;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;

   localparam logic [1:0] SRCB_RT    = 2'b00;
   localparam logic [1:0] SRCB_FOUR  = 2'b01;
   localparam logic [1:0] SRCB_IMM   = 2'b10;
   localparam logic [1:0] SRCB_IMMSH = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/alu_dec.sv
// ALU control decoder: {ALUOp, Funct} -> {ALUCtr, funct_illegal}.
module alu_dec
   import mips_ctrl_pkg::*;
#(
   parameter int unsigned ALUCTR_W = 4
) (
   input  aluop_e              aluop_i,
   input  logic [5:0]          funct_i,
   output logic [ALUCTR_W-1:0] aluctr_o,
   output logic                funct_illegal_o
);

   logic [3:0] code;

   // Map the ALU operation class (and Funct for R-type) to an ALU code.
   always_comb begin
      code            = ALU_ADD;
      funct_illegal_o = 1'b0;
      unique case (aluop_i)
         ALUOP_ADD: code = ALU_ADD;
         ALUOP_SUB: code = ALU_SUB;
         ALUOP_OR:  code = ALU_OR;
         ALUOP_FUNCT: begin
            case (funct_i)
               FN_ADD:  code = ALU_ADD;
               FN_SUB:  code = ALU_SUB;
               FN_AND:  code = ALU_AND;
               FN_OR:   code = ALU_OR;
               FN_SLT:  code = ALU_SLT;
               default: begin
                  code            = ALU_ADD;
                  funct_illegal_o = 1'b1;
               end
            endcase
         end
         default: code = ALU_ADD;
      endcase
   end

   assign aluctr_o = ALUCTR_W'(code);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS controller: Moore FSM, shared-datapath control decode,
// memory-ready stalls, illegal-encoding flag and retired-instruction count.
module multicycle_ctrl
   import mips_ctrl_pkg::*;
#(
   parameter int unsigned ALUCTR_W    = 4,
   parameter int unsigned CNT_W       = 32,
   parameter bit          MEM_WAIT_EN = 1'b1,
   parameter bit          BNE_EN      = 1'b1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [5:0]          OpCode,
   input  logic [5:0]          Funct,
   input  logic                Zero,
   input  logic                mem_ready,
   output logic                PCWrite,
   output logic                PCWriteCond,
   output logic                PCWriteEff,
   output logic                IorD,
   output logic                MemRead,
   output logic                MemWr,
   output logic                IRWrite,
   output logic                Mem2Reg,
   output logic                RegDst,
   output logic                RegWr,
   output logic                ALUSrcA,
   output logic [1:0]          ALUSrcB,
   output logic [1:0]          PCSrc,
   output logic [ALUCTR_W-1:0] ALUCtr,
   output logic                illegal,
   output logic [CNT_W-1:0]    retired
);

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    retired_q, retired_d;
   logic                mem_rdy;
   logic                is_bne;
   logic                op_illegal;
   logic                funct_illegal;
   logic                alu_en;
   logic                retire;
   aluop_e              aluop;
   logic [ALUCTR_W-1:0] dec_aluctr;

   assign mem_rdy = MEM_WAIT_EN ? mem_ready : 1'b1;
   assign is_bne  = BNE_EN && (OpCode == OP_BNE);

   alu_dec #(
      .ALUCTR_W (ALUCTR_W)
   ) u_alu_dec (
      .aluop_i         (aluop),
      .funct_i         (Funct),
      .aluctr_o        (dec_aluctr),
      .funct_illegal_o (funct_illegal)
   );

   // Next-state selection, including the opcode legality check used in DECODE.
   always_comb begin
      state_d    = state_q;
      op_illegal = 1'b0;
      unique case (state_q)
         S_FETCH:  state_d = mem_rdy ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (OpCode)
               OP_RTYPE:       state_d = S_REXEC;
               OP_LW, OP_SW:   state_d = S_MEMADR;
               OP_BEQ:         state_d = S_BRANCH;
               OP_BNE: begin
                  if (BNE_EN) begin
                     state_d = S_BRANCH;
                  end else begin
                     state_d    = S_FETCH;
                     op_illegal = 1'b1;
                  end
               end
               OP_J:           state_d = S_JUMP;
               OP_ADDI, OP_ORI: state_d = S_IEXEC;
               default: begin
                  state_d    = S_FETCH;
                  op_illegal = 1'b1;
               end
            endcase
         end
         S_MEMADR: state_d = (OpCode == OP_SW) ? S_MEMWR : S_MEMRD;
         S_MEMRD:  state_d = mem_rdy ? S_MEMWB : S_MEMRD;
         S_MEMWB:  state_d = S_FETCH;
         S_MEMWR:  state_d = mem_rdy ? S_FETCH : S_MEMWR;
         S_REXEC:  state_d = funct_illegal ? S_FETCH : S_RWB;
         S_RWB:    state_d = S_FETCH;
         S_IEXEC:  state_d = S_IWB;
         S_IWB:    state_d = S_FETCH;
         S_BRANCH: state_d = S_FETCH;
         S_JUMP:   state_d = S_FETCH;
         default:  state_d = S_FETCH;
      endcase
   end

   // Moore output decode; only FETCH write enables look at mem_ready.
   always_comb begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWr       = 1'b0;
      IRWrite     = 1'b0;
      Mem2Reg     = 1'b0;
      RegDst      = 1'b0;
      RegWr       = 1'b0;
      ALUSrcA     = 1'b0;
      ALUSrcB     = SRCB_RT;
      PCSrc       = PCSRC_ALU;
      aluop       = ALUOP_ADD;
      alu_en      = 1'b0;
      unique case (state_q)
         S_FETCH: begin
            MemRead = 1'b1;
            ALUSrcB = SRCB_FOUR;
            alu_en  = 1'b1;
            IRWrite = mem_rdy;
            PCWrite = mem_rdy;
         end
         S_DECODE: begin
            ALUSrcB = SRCB_IMMSH;
            alu_en  = 1'b1;
         end
         S_MEMADR: begin
            ALUSrcA = 1'b1;
            ALUSrcB = SRCB_IMM;
            alu_en  = 1'b1;
         end
         S_MEMRD: begin
            IorD    = 1'b1;
            MemRead = 1'b1;
         end
         S_MEMWB: begin
            RegWr   = 1'b1;
            Mem2Reg = 1'b1;
         end
         S_MEMWR: begin
            IorD  = 1'b1;
            MemWr = 1'b1;
         end
         S_REXEC: begin
            ALUSrcA = 1'b1;
            aluop   = ALUOP_FUNCT;
            alu_en  = 1'b1;
         end
         S_RWB: begin
            RegWr  = 1'b1;
            RegDst = 1'b1;
         end
         S_IEXEC: begin
            ALUSrcA = 1'b1;
            ALUSrcB = SRCB_IMM;
            aluop   = (OpCode == OP_ORI) ? ALUOP_OR : ALUOP_ADD;
            alu_en  = 1'b1;
         end
         S_IWB: RegWr = 1'b1;
         S_BRANCH: begin
            ALUSrcA     = 1'b1;
            aluop       = ALUOP_SUB;
            alu_en      = 1'b1;
            PCWriteCond = 1'b1;
            PCSrc       = PCSRC_ALUOUT;
         end
         S_JUMP: begin
            PCWrite = 1'b1;
            PCSrc   = PCSRC_JUMP;
         end
         default: ;
      endcase
   end

   assign ALUCtr     = alu_en ? dec_aluctr : '0;
   assign illegal    = ((state_q == S_DECODE) && op_illegal) ||
                       ((state_q == S_REXEC) && funct_illegal);
   assign PCWriteEff = PCWrite | (PCWriteCond & (Zero ^ is_bne));

   // Last cycle of every legal instruction bumps the retired count.
   always_comb begin
      unique case (state_q)
         S_MEMWB, S_RWB, S_IWB, S_BRANCH, S_JUMP: retire = 1'b1;
         S_MEMWR: retire = mem_rdy;
         default: retire = 1'b0;
      endcase
      retired_d = retire ? retired_q + CNT_W'(1) : retired_q;
   end

   // State and counter registers with asynchronous reset to FETCH / zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_FETCH;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         retired_q <= retired_d;
      end
   end

   assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl; a second instance has bne disabled.
module tb_multicycle_ctrl;

   logic       clk, rst_n, Zero, mem_ready;
   logic [5:0] OpCode, Funct;

   logic       PCWrite, PCWriteCond, PCWriteEff, IorD, MemRead, MemWr, IRWrite;
   logic       Mem2Reg, RegDst, RegWr, ALUSrcA, illegal;
   logic [1:0] ALUSrcB, PCSrc;
   logic [3:0] ALUCtr;
   logic [3:0] retired;

   logic        nb_PCWrite, nb_PCWriteCond, nb_PCWriteEff, nb_IorD, nb_MemRead, nb_MemWr;
   logic        nb_IRWrite, nb_Mem2Reg, nb_RegDst, nb_RegWr, nb_ALUSrcA, nb_illegal;
   logic [1:0]  nb_ALUSrcB, nb_PCSrc;
   logic [3:0]  nb_ALUCtr;
   logic [31:0] nb_retired;

   int nchk = 0;
   int npass = 0;
   int exp_ret = 0;

   multicycle_ctrl #(
      .ALUCTR_W    (4),
      .CNT_W       (4),
      .MEM_WAIT_EN (1'b1),
      .BNE_EN      (1'b1)
   ) dut (
      .clk (clk), .rst_n (rst_n), .OpCode (OpCode), .Funct (Funct),
      .Zero (Zero), .mem_ready (mem_ready),
      .PCWrite (PCWrite), .PCWriteCond (PCWriteCond), .PCWriteEff (PCWriteEff),
      .IorD (IorD), .MemRead (MemRead), .MemWr (MemWr), .IRWrite (IRWrite),
      .Mem2Reg (Mem2Reg), .RegDst (RegDst), .RegWr (RegWr), .ALUSrcA (ALUSrcA),
      .ALUSrcB (ALUSrcB), .PCSrc (PCSrc), .ALUCtr (ALUCtr),
      .illegal (illegal), .retired (retired)
   );

   multicycle_ctrl #(
      .ALUCTR_W    (4),
      .CNT_W       (32),
      .MEM_WAIT_EN (1'b1),
      .BNE_EN      (1'b0)
   ) dut_nb (
      .clk (clk), .rst_n (rst_n), .OpCode (OpCode), .Funct (Funct),
      .Zero (Zero), .mem_ready (mem_ready),
      .PCWrite (nb_PCWrite), .PCWriteCond (nb_PCWriteCond), .PCWriteEff (nb_PCWriteEff),
      .IorD (nb_IorD), .MemRead (nb_MemRead), .MemWr (nb_MemWr), .IRWrite (nb_IRWrite),
      .Mem2Reg (nb_Mem2Reg), .RegDst (nb_RegDst), .RegWr (nb_RegWr), .ALUSrcA (nb_ALUSrcA),
      .ALUSrcB (nb_ALUSrcB), .PCSrc (nb_PCSrc), .ALUCtr (nb_ALUCtr),
      .illegal (nb_illegal), .retired (nb_retired)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nchk++;
      assert (obs === exp) npass++;
      else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   initial begin
      rst_n     = 1'b0;
      mem_ready = 1'b1;
      Zero      = 1'b0;
      OpCode    = 6'b100011;
      Funct     = 6'b000000;
      #1;
      // reset state: FETCH outputs
      chk("rst_memread", MemRead, 1);
      chk("rst_irwrite", IRWrite, 1);
      chk("rst_pcwrite", PCWrite, 1);
      chk("rst_regwr",   RegWr,   0);
      chk("rst_memwr",   MemWr,   0);
      chk("rst_retired", retired, 0);
      mem_ready = 1'b0;
      #1;
      chk("fetch_stall_irwrite", IRWrite, 0);
      chk("fetch_stall_pceff",   PCWriteEff, 0);
      rst_n = 1'b1;

      // lw, first FETCH cycle stalled once
      step();
      chk("lw_fetch_memread", MemRead, 1);
      chk("lw_fetch_iord",    IorD, 0);
      chk("lw_fetch_srcb",    ALUSrcB, 2'b01);
      chk("lw_fetch_aluctr",  ALUCtr, 4'b0010);
      chk("lw_fetch_irw_lo",  IRWrite, 0);
      mem_ready = 1'b1;
      #1;
      chk("lw_fetch_irw_hi",  IRWrite, 1);
      step(); // DECODE
      chk("lw_dec_srcb",    ALUSrcB, 2'b11);
      chk("lw_dec_memread", MemRead, 0);
      step(); // MEMADR
      chk("lw_adr_srca", ALUSrcA, 1);
      chk("lw_adr_srcb", ALUSrcB, 2'b10);
      step(); // MEMRD
      chk("lw_rd_iord",    IorD, 1);
      chk("lw_rd_memread", MemRead, 1);
      step(); // MEMWB
      chk("lw_wb_regwr",   RegWr, 1);
      chk("lw_wb_mem2reg", Mem2Reg, 1);
      chk("lw_wb_regdst",  RegDst, 0);
      chk("lw_wb_retired", retired, 0);
      step(); // FETCH
      chk("lw_done_retired", retired, 1);

      // sw with three stalled MEMWR cycles
      OpCode = 6'b101011;
      step(); step(); step(); // DECODE, MEMADR, MEMWR
      mem_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (i == 3) mem_ready = 1'b1;
         #1;
         chk("sw_memwr", MemWr, 1);
         chk("sw_iord",  IorD, 1);
         chk("sw_retired_hold", retired, 1);
         step();
      end
      chk("sw_done_memwr",   MemWr, 0);
      chk("sw_done_retired", retired, 2);

      // R-type slt
      OpCode = 6'b000000;
      Funct  = 6'b101010;
      step(); step(); // DECODE, REXEC
      chk("slt_aluctr",  ALUCtr, 4'b0111);
      chk("slt_srcb",    ALUSrcB, 2'b00);
      chk("slt_illegal", illegal, 0);
      step(); // RWB
      chk("slt_regwr",  RegWr, 1);
      chk("slt_regdst", RegDst, 1);
      step();
      chk("slt_retired", retired, 3);

      // R-type sub
      Funct = 6'b100010;
      step(); step();
      chk("sub_aluctr", ALUCtr, 4'b0110);
      step(); step();
      chk("sub_retired", retired, 4);

      // unknown Funct
      Funct = 6'b000111;
      step(); step(); // REXEC
      chk("badfn_illegal", illegal, 1);
      chk("badfn_aluctr",  ALUCtr, 4'b0010);
      chk("badfn_regwr",   RegWr, 0);
      step(); // FETCH
      chk("badfn_illegal_off", illegal, 0);
      chk("badfn_regwr_off",   RegWr, 0);
      chk("badfn_retired",     retired, 4);
      chk("badfn_fetch",       MemRead, 1);

      // beq
      OpCode = 6'b000100;
      Zero   = 1'b1;
      step(); step(); // BRANCH
      chk("beq_cond",   PCWriteCond, 1);
      chk("beq_pcsrc",  PCSrc, 2'b01);
      chk("beq_aluctr", ALUCtr, 4'b0110);
      chk("beq_eff_z1", PCWriteEff, 1);
      Zero = 1'b0;
      #1;
      chk("beq_eff_z0", PCWriteEff, 0);
      step();
      chk("beq_retired", retired, 5);

      // bne: taken on Zero=0 when enabled; illegal when disabled
      OpCode = 6'b000101;
      step(); // DECODE
      chk("bne_illegal_en",  illegal, 0);
      chk("bne_illegal_dis", nb_illegal, 1);
      step(); // BRANCH
      chk("bne_eff_z0", PCWriteEff, 1);
      Zero = 1'b1;
      #1;
      chk("bne_eff_z1", PCWriteEff, 0);
      Zero = 1'b0;
      step();
      chk("bne_retired", retired, 6);

      // j
      OpCode = 6'b000010;
      step(); step(); // JUMP
      chk("j_pcwrite", PCWrite, 1);
      chk("j_pcsrc",   PCSrc, 2'b10);
      chk("j_eff",     PCWriteEff, 1);
      step();
      chk("j_retired", retired, 7);

      // addi
      OpCode = 6'b001000;
      step(); step(); // IEXEC
      chk("addi_aluctr", ALUCtr, 4'b0010);
      chk("addi_srcb",   ALUSrcB, 2'b10);
      step(); // IWB
      chk("addi_regwr",  RegWr, 1);
      chk("addi_regdst", RegDst, 0);
      step();
      chk("addi_retired", retired, 8);

      // ori
      OpCode = 6'b001101;
      step(); step();
      chk("ori_aluctr", ALUCtr, 4'b0001);
      step(); step();
      chk("ori_retired", retired, 9);

      // unknown opcode
      OpCode = 6'b111111;
      step(); // DECODE
      chk("badop_illegal", illegal, 1);
      step(); // FETCH
      chk("badop_illegal_off", illegal, 0);
      chk("badop_retired",     retired, 9);

      // reset asserted while stalled in MEMRD
      OpCode = 6'b100011;
      step(); step(); step(); // DECODE, MEMADR, MEMRD
      mem_ready = 1'b0;
      #1;
      chk("rstmid_iord_pre", IorD, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rstmid_iord",    IorD, 0);
      chk("rstmid_memread", MemRead, 1);
      chk("rstmid_memwr",   MemWr, 0);
      chk("rstmid_regwr",   RegWr, 0);
      chk("rstmid_irwrite", IRWrite, 0);
      chk("rstmid_retired", retired, 0);
      rst_n = 1'b1;
      step(); // held in FETCH by mem_ready=0
      chk("rstmid_fetch_hold", MemRead, 1);
      mem_ready = 1'b1;

      // 16 jumps wrap the 4-bit counter
      OpCode  = 6'b000010;
      exp_ret = 0;
      for (int n = 0; n < 16; n++) begin
         step(); step(); step();
         exp_ret = (exp_ret + 1) % 16;
         chk("wrap_retired", retired, 32'(exp_ret));
      end

      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

- Parametrised multi-cycle successor to the single-cycle MIPS controller.
- A Moore FSM sequences each instruction through fetch, decode, execute, memory and write-back, and drives the shared-datapath control signals.
- Stalls on a memory ready handshake, flags illegal encodings, and counts retired instructions.
- Sits between the instruction register (OpCode/Funct) and the multi-cycle datapath and memory port.

## Interface

Parameters:
- ALUCTR_W, 4: width of ALU control code.
- CNT_W, 32: width of retired-instruction counter.
- MEM_WAIT_EN, 1: 1 honours `mem_ready`; 0 treats `mem_ready` as constant 1.
- BNE_EN, 1: 1 decodes bne (000101); 0 makes it illegal.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- OpCode  in  6  instruction[31:26], valid from DECODE onward.
- Funct  in  6  instruction[5:0].
- Zero  in  1  ALU zero flag.
- mem_ready  in  1  memory access completes this cycle.
- PCWrite  out  1  unconditional PC load.
- PCWriteCond  out  1  PC load gated by branch condition.
- PCWriteEff  out  1  `PCWrite | (PCWriteCond & (Zero ^ is_bne))`.
- IorD  out  1  0 = PC address, 1 = ALUOut address.
- MemRead, MemWr  out  1 each  memory strobes.
- IRWrite  out  1  instruction register load.
- Mem2Reg, RegDst, RegWr  out  1 each  write-back controls.
- ALUSrcA  out  1  0 = PC, 1 = rs.
- ALUSrcB  out  2  00 = rt, 01 = 4, 10 = signext imm, 11 = imm<<2.
- PCSrc  out  2  00 = ALU, 01 = ALUOut, 10 = jump target.
- ALUCtr  out  ALUCTR_W  ALU code.
- illegal  out  1  one-cycle pulse on unknown OpCode or Funct.
- retired  out  CNT_W  instructions completed.

## Operation

- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, REXEC, RWB, IEXEC, IWB, BRANCH, JUMP.
- FETCH: IorD=0, MemRead=1, ALUSrcA=0, ALUSrcB=01, ALUCtr=ADD, PCSrc=00.
  - IRWrite=PCWrite=mem_ready.
  - Stay while !mem_ready; go to DECODE on mem_ready.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUCtr=ADD. Next state by OpCode:
  - 000000 → REXEC.
  - 100011 (lw) or 101011 (sw) → MEMADR.
  - 000100 (beq), or 000101 (bne) when BNE_EN → BRANCH.
  - 000010 → JUMP.
  - 001000 (addi) or 001101 (ori) → IEXEC.
  - Anything else: pulse illegal and go to FETCH; not retired.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ADD. Go to MEMRD (lw) or MEMWR (sw).
- MEMRD: IorD=1, MemRead=1. Hold until mem_ready, then MEMWB.
- MEMWB: RegWr=1, Mem2Reg=1, RegDst=0. Go to FETCH.
- MEMWR: IorD=1, MemWr=1. Hold until mem_ready, then FETCH.
- REXEC: ALUSrcA=1, ALUSrcB=00, ALUCtr from Funct:
  - 100000 → ADD 0010; 100010 → SUB 0110; 100100 → AND 0000; 100101 → OR 0001; 101010 → SLT 0111.
  - Unknown Funct: ALUCtr=ADD, illegal pulse, go to FETCH with no write-back and no retire.
  - Otherwise go to RWB.
- RWB: RegWr=1, RegDst=1, Mem2Reg=0. Go to FETCH.
- IEXEC: ALUSrcA=1, ALUSrcB=10, ALUCtr=ADD (addi) or OR (ori). Go to IWB.
- IWB: RegWr=1, RegDst=0. Go to FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, SUB, PCWriteCond=1, PCSrc=01. Go to FETCH.
- JUMP: PCWrite=1, PCSrc=10. Go to FETCH.
- Any signal not listed for a state is 0.
- `retired` increments on the last cycle of each legal instruction (transition into FETCH from MEMWB, MEMWR-with-ready, RWB, IWB, BRANCH, JUMP). It wraps modulo 2^CNT_W.

## Timing

- Outputs are combinational decodes of the state register (plus `mem_ready` for FETCH write enables, plus OpCode/Funct for ALUCtr and illegal).
- Reset (rst_n low, asynchronous): state=FETCH, retired=0.
  - Outputs then take FETCH values: MemRead=1, IRWrite=PCWrite=mem_ready, all other enables 0.
- Latency with zero wait:
  - beq/bne/j: 3 cycles.
  - R-type, addi/ori, sw: 4 cycles.
  - lw: 5 cycles.
  - Each cycle `mem_ready` is low in FETCH/MEMRD/MEMWR adds one cycle.
- `mem_ready` high in a non-memory state is ignored.
- Reset asserted mid-instruction aborts immediately. No write enable is asserted after the reset edge except the FETCH enables gated by `mem_ready`.
- Illegal pulse is exactly one cycle, in DECODE or REXEC.

## Structure

- Package `mips_ctrl_pkg`:
  - State enum.
  - Opcode and Funct localparams.
  - ALUCtr codes.
  - ALUSrcB/PCSrc encodings.
- Sub-module `alu_dec`: combinational map {ALUOp 2b, Funct} → {ALUCtr, funct_illegal}.
  - ALUOp 00 = ADD, 01 = SUB, 10 = Funct decode, 11 = OR.
- Top holds the FSM, output decode and retired counter.

## Test plan

- Reset then lw with mem_ready=1: states FETCH, DECODE, MEMADR, MEMRD, MEMWB → RegWr=1, Mem2Reg=1 in cycle 5; retired 0→1.
- sw with mem_ready held low 3 cycles in MEMWR → MemWr high for 4 cycles, IorD=1 throughout; retired increments once.
- R-type Funct=101010 → ALUCtr=0111 in REXEC, RegDst=1 in RWB.
- Funct=000111 → illegal pulse in REXEC, RegWr never asserted, retired unchanged.
- beq with Zero=1 → PCWriteEff=1; Zero=0 → 0.
  - BNE_EN=1, OpCode 000101, Zero=0 → PCWriteEff=1.
  - BNE_EN=0, same OpCode → illegal in DECODE.
- rst_n low mid-MEMRD → state FETCH asynchronously, MemWr=RegWr=0, retired=0.
- CNT_W=4: 16 legal instructions → retired wraps 15→0.
